cnn_iter_ctrl: RTL and testbench

//  Sequencer for the 4x4 cellular-NN cell array. Loads the templates, runs a

---
 rtl/cnn_pkg.sv | 31 +++
 rtl/cnn_maxdiff.sv | 35 +++
 rtl/cnn_iter_ctrl.sv | 130 +++++++++++++
 tb/tb_cnn_iter_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the cellular-NN iteration controller.
// Holds cell width, cell count, FSM encodings and diff helpers.
package cnn_pkg;

    localparam int CNN_WIDTH = 16;
    localparam int N_CELLS   = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // |a-b| of two signed cells, one bit wider so it cannot overflow.
    function automatic logic [CNN_WIDTH:0] abs_diff(
        input logic [CNN_WIDTH-1:0] a,
        input logic [CNN_WIDTH-1:0] b
    );
        logic signed [CNN_WIDTH:0] d;
        d = $signed({a[CNN_WIDTH-1], a}) - $signed({b[CNN_WIDTH-1], b});
        return d[CNN_WIDTH] ? $unsigned(-d) : $unsigned(d);
    endfunction

    function automatic logic [CNN_WIDTH:0] max2(
        input logic [CNN_WIDTH:0] a,
        input logic [CNN_WIDTH:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cnn_maxdiff.sv
// Combinational max over 16 cells of |a[k]-b[k]|.
// Ports: a, b = packed cell vectors (cell 0 in LSBs); maxd = WIDTH+1 bit result.
module cnn_maxdiff
    import cnn_pkg::*;
(
    input  logic [N_CELLS*CNN_WIDTH-1:0] a,
    input  logic [N_CELLS*CNN_WIDTH-1:0] b,
    output logic [CNN_WIDTH:0]           maxd
);

    logic [CNN_WIDTH:0] l0 [16];
    logic [CNN_WIDTH:0] l1 [8];
    logic [CNN_WIDTH:0] l2 [4];
    logic [CNN_WIDTH:0] l3 [2];

    for (genvar k = 0; k < 16; k++) begin : g_abs
        assign l0[k] = abs_diff(a[k*CNN_WIDTH +: CNN_WIDTH],
                                b[k*CNN_WIDTH +: CNN_WIDTH]);
    end

    for (genvar k = 0; k < 8; k++) begin : g_l1
        assign l1[k] = max2(l0[2*k], l0[2*k+1]);
    end

    for (genvar k = 0; k < 4; k++) begin : g_l2
        assign l2[k] = max2(l1[2*k], l1[2*k+1]);
    end

    for (genvar k = 0; k < 2; k++) begin : g_l3
        assign l3[k] = max2(l2[2*k], l2[2*k+1]);
    end

    assign maxd = max2(l3[0], l3[1]);

endmodule

// File: rtl/cnn_iter_ctrl.sv
// Sequencer for the 4x4 CNN array: load, sweep, snapshot, converge check.
// Ports: clk/rst, start/num_iter/tol (run request), y_in (array outputs),
// ld_en/arr_sync/arr_en (array controls), y_out/iter_count/busy/done/converged.
module cnn_iter_ctrl
    import cnn_pkg::*;
#(
    parameter int WIDTH     = CNN_WIDTH,
    parameter int ITER_W    = 8,
    parameter int SWEEP_LEN = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ITER_W-1:0]     num_iter,
    input  logic [WIDTH-1:0]      tol,
    input  logic [16*WIDTH-1:0]   y_in,
    output logic                  ld_en,
    output logic                  arr_sync,
    output logic                  arr_en,
    output logic [16*WIDTH-1:0]   y_out,
    output logic [ITER_W-1:0]     iter_count,
    output logic                  busy,
    output logic                  done,
    output logic                  converged
);

    localparam logic [15:0] LAST = 16'(SWEEP_LEN - 1);

    logic [2:0]            state_q, state_d;
    logic [15:0]           sweep_cnt_q, sweep_cnt_d;
    logic [ITER_W-1:0]     iter_count_q, iter_count_d;
    logic [ITER_W-1:0]     num_iter_q, num_iter_d;
    logic [WIDTH-1:0]      tol_q, tol_d;
    logic [16*WIDTH-1:0]   y_out_q, y_out_d;
    logic                  converged_q, converged_d;
    logic [WIDTH:0]        maxd;
    logic [ITER_W-1:0]     iter_next;

    cnn_maxdiff u_maxdiff (
        .a    (y_in),
        .b    (y_out_q),
        .maxd (maxd)
    );

    assign iter_next = iter_count_q + ITER_W'(1);

    always_comb begin
        state_d      = state_q;
        sweep_cnt_d  = sweep_cnt_q;
        iter_count_d = iter_count_q;
        num_iter_d   = num_iter_q;
        tol_d        = tol_q;
        y_out_d      = y_out_q;
        converged_d  = converged_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    iter_count_d = '0;
                    converged_d  = 1'b0;
                    if (num_iter != '0) begin
                        num_iter_d = num_iter;
                        tol_d      = tol;
                        state_d    = ST_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_LOAD: begin
                sweep_cnt_d = '0;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                if (sweep_cnt_q == LAST) begin
                    sweep_cnt_d = '0;
                    state_d     = ST_CHECK;
                end else begin
                    sweep_cnt_d = sweep_cnt_q + 16'd1;
                end
            end
            ST_CHECK: begin
                y_out_d      = y_in;
                iter_count_d = iter_next;
                // The first sweep has no meaningful previous snapshot.
                if (iter_count_q != '0 && maxd <= {1'b0, tol_q}) begin
                    converged_d = 1'b1;
                    state_d     = ST_DONE;
                end else if (iter_next == num_iter_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sweep_cnt_q  <= '0;
            iter_count_q <= '0;
            num_iter_q   <= '0;
            tol_q        <= '0;
            y_out_q      <= '0;
            converged_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sweep_cnt_q  <= sweep_cnt_d;
            iter_count_q <= iter_count_d;
            num_iter_q   <= num_iter_d;
            tol_q        <= tol_d;
            y_out_q      <= y_out_d;
            converged_q  <= converged_d;
        end
    end

    // Strobes decode straight from the state flop so reset kills them at once.
    assign ld_en      = (state_q == ST_LOAD);
    assign arr_sync   = (state_q == ST_LOAD);
    assign arr_en     = (state_q == ST_RUN);
    assign busy       = (state_q == ST_LOAD) || (state_q == ST_RUN)
                     || (state_q == ST_CHECK);
    assign done       = (state_q == ST_DONE);
    assign y_out      = y_out_q;
    assign iter_count = iter_count_q;
    assign converged  = converged_q;

endmodule

// File: tb/tb_cnn_iter_ctrl.sv
// Self-checking bench for cnn_iter_ctrl.
// Expected run results are queued at start and compared when done pulses.
module tb_cnn_iter_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [7:0]   num_iter = '0;
    logic [15:0]  tol = '0;
    logic [255:0] y_in = '0;
    logic         ld_en, arr_sync, arr_en, busy, done, converged;
    logic [255:0] y_out;
    logic [7:0]   iter_count;

    int errors = 0;
    int checks = 0;
    int mode = 0;
    int sw = 0;
    bit chk_prev = 1'b0;

    typedef struct {
        int           lat;
        int           iter;
        bit           conv;
        logic [255:0] y;
        int           nld;
        int           nen;
    } exp_t;

    exp_t sb[$];

    cnn_iter_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_iter   (num_iter),
        .tol        (tol),
        .y_in       (y_in),
        .ld_en      (ld_en),
        .arr_sync   (arr_sync),
        .arr_en     (arr_en),
        .y_out      (y_out),
        .iter_count (iter_count),
        .busy       (busy),
        .done       (done),
        .converged  (converged)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] pat(input int md, input int s);
        logic [255:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) begin
            case (md)
                0:       v[k*16 +: 16] = 16'(s * 1000 + k * 7 + 1);
                1:       v[k*16 +: 16] = 16'd100;
                default: v[k*16 +: 16] = (s != 0 && k == 0) ? 16'h7fff
                                                            : 16'h8000;
            endcase
        end
        return v;
    endfunction

    // Array model: y_in moves to the next sweep's pattern after each CHECK.
    always @(negedge clk) begin
        if (ld_en) sw = 0;
        else if (chk_prev) sw = sw + 1;
        chk_prev = busy && !arr_en && !ld_en;
        y_in = pat(mode, sw);
    end

    task automatic run_case(input int ni, input logic [15:0] t, input int md,
                            input exp_t e, input bit poke);
        int cyc, nld, nsy, nen;
        bit seen;
        exp_t x;
        sb.push_back(e);
        @(negedge clk);
        mode = md;
        num_iter = 8'(ni);
        tol = t;
        start = 1'b1;
        cyc = 0; nld = 0; nsy = 0; nen = 0; seen = 1'b0;
        while (cyc < 2000 && !seen) begin
            @(posedge clk);
            #1;
            cyc++;
            start = poke && (cyc == 6 || cyc == 25);
            if (poke) num_iter = 8'd1;
            nld += int'(ld_en);
            nsy += int'(arr_sync);
            nen += int'(arr_en);
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check("done_seen", 256'(seen), 256'(1));
        x = sb.pop_front();
        check("latency", 256'(cyc), 256'(x.lat));
        check("iter_count", 256'(iter_count), 256'(x.iter));
        check("converged", 256'(converged), 256'(x.conv));
        check("y_out", y_out, x.y);
        check("ld_en_cnt", 256'(nld), 256'(x.nld));
        check("sync_cnt", 256'(nsy), 256'(x.nld));
        check("arr_en_cnt", 256'(nen), 256'(x.nen));
        @(posedge clk);
        #1;
        check("done_pulse", 256'(done), 256'(0));
        check("conv_hold", 256'(converged), 256'(x.conv));
        check("busy_idle", 256'(busy), 256'(0));
    endtask

    initial begin
        int n;
        exp_t e;
        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", {ld_en, arr_sync, arr_en, busy, done, converged,
                          iter_count, y_out}, '0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            n += int'(arr_en | ld_en | busy | done);
        end
        check("idle_quiet", 256'(n), 256'(0));

        // Three sweeps, data never settles
        e = '{53, 3, 1'b0, pat(0, 2), 1, 48};
        run_case(3, 16'd0, 0, e, 1'b0);

        // Constant data converges on the second sweep
        e = '{36, 2, 1'b1, pat(1, 0), 1, 32};
        run_case(10, 16'd4, 1, e, 1'b0);

        // Single sweep can never report convergence
        e = '{19, 1, 1'b0, pat(1, 0), 1, 16};
        run_case(1, 16'hffff, 1, e, 1'b0);

        // Full-range difference 65535 against max tolerance
        e = '{36, 2, 1'b1, pat(2, 1), 1, 32};
        run_case(5, 16'hffff, 2, e, 1'b0);

        // Same difference, tolerance one short
        e = '{36, 2, 1'b0, pat(2, 1), 1, 32};
        run_case(2, 16'hfffe, 2, e, 1'b0);

        // Zero iterations: immediate done, snapshot untouched
        e = '{1, 0, 1'b0, pat(2, 1), 0, 0};
        run_case(0, 16'd0, 0, e, 1'b0);

        // Reset in the middle of a sweep
        @(negedge clk);
        mode = 0;
        num_iter = 8'd5;
        tol = '0;
        start = 1'b1;
        n = 0;
        for (int i = 0; i < 100 && n < 8; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            n += int'(arr_en);
        end
        check("run_reached", 256'(n), 256'(8));
        rst = 1'b1;
        #1;
        check("rst_arr_en", 256'(arr_en), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_iter", 256'(iter_count), 256'(0));
        check("rst_yout", y_out, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Restart after reset; start pulses while busy are ignored
        e = '{36, 2, 1'b0, pat(0, 1), 1, 32};
        run_case(2, 16'd0, 0, e, 1'b1);

        check("sb_empty", 256'(sb.size()), 256'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
